// File: rtl/dcache_pkg.sv
// Shared types, geometry and helpers for the direct-mapped write-through data cache.
package dcache_pkg;

   localparam int LINES_DEF = 16;
   localparam int WORDS_DEF = 4;
   localparam int OFF_W     = $clog2(WORDS_DEF);
   localparam int IDX_W     = $clog2(LINES_DEF);
   localparam int TAG_W     = 32 - IDX_W - OFF_W - 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      WRITE  = 2'd2,
      DONE   = 2'd3
   } state_e;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: one combinational read port, one byte-enabled write port.
module dcache_array
   import dcache_pkg::*;
#(
   parameter int LINES      = LINES_DEF,
   parameter int WORDS      = WORDS_DEF,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [IDX_W-1:0]      rd_idx_i,
   input  logic [OFF_W-1:0]      rd_off_i,
   output logic                  rd_valid_o,
   output logic [TAG_W-1:0]      rd_tag_o,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   input  logic [IDX_W-1:0]      wr_idx_i,
   input  logic [OFF_W-1:0]      wr_off_i,
   input  logic [3:0]            wr_be_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  tag_we_i,
   input  logic                  tag_valid_i,
   input  logic [TAG_W-1:0]      tag_i
);

   logic [LINES-1:0]      valid_q;
   logic [TAG_W-1:0]      tag_q  [LINES];
   logic [DATA_WIDTH-1:0] data_q [LINES][WORDS];

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_data_o  = data_q[rd_idx_i][rd_off_i];

   // Only the valid bits need a reset; tag and data are qualified by them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (tag_we_i) begin
         valid_q[wr_idx_i] <= tag_valid_i;
      end
   end

   always_ff @(posedge clk) begin
      if (tag_we_i) begin
         tag_q[wr_idx_i] <= tag_i;
      end
      if (|wr_be_i) begin
         data_q[wr_idx_i][wr_off_i] <= byte_merge(data_q[wr_idx_i][wr_off_i], wr_data_i, wr_be_i);
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate D-cache controller for the MEM stage.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int LINES      = LINES_DEF,
   parameter int WORDS      = WORDS_DEF,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpu_rd,
   input  logic                  cpu_wr,
   input  logic [DATA_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   input  logic [3:0]            cpu_wstrb,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_stall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_wstrb,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int AW = DATA_WIDTH - 2;

   state_e                state_q, state_d;
   logic [OFF_W-1:0]      beat_q, beat_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [3:0]            wstrb_q, wstrb_d;
   logic                  hit_q, hit_d;

   logic [AW-1:0]         rd_addr;
   logic                  rd_valid, hit;
   logic [TAG_W-1:0]      rd_tag;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [IDX_W-1:0]      wr_idx;
   logic [OFF_W-1:0]      wr_off;
   logic [3:0]            wr_be;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  tag_we, tag_valid;
   logic [TAG_W-1:0]      tag_wd;
   logic                  unused_byte_off;

   assign unused_byte_off = ^cpu_addr[1:0];

   // DONE presents the word of the request just serviced, not whatever is on the bus now.
   assign rd_addr   = (state_q == DONE) ? addr_q : cpu_addr[DATA_WIDTH-1:2];
   assign hit       = rd_valid && (rd_tag == rd_addr[AW-1 -: TAG_W]);
   assign cpu_rdata = rd_data;

   dcache_array #(.LINES(LINES), .WORDS(WORDS), .DATA_WIDTH(DATA_WIDTH)) u_array (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_idx_i   (rd_addr[OFF_W +: IDX_W]),
      .rd_off_i   (rd_addr[OFF_W-1:0]),
      .rd_valid_o (rd_valid),
      .rd_tag_o   (rd_tag),
      .rd_data_o  (rd_data),
      .wr_idx_i   (wr_idx),
      .wr_off_i   (wr_off),
      .wr_be_i    (wr_be),
      .wr_data_i  (wr_data),
      .tag_we_i   (tag_we),
      .tag_valid_i(tag_valid),
      .tag_i      (tag_wd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         beat_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         hit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         hit_q   <= hit_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      hit_d     = hit_q;
      cpu_stall = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      wr_idx    = addr_q[OFF_W +: IDX_W];
      wr_off    = addr_q[OFF_W-1:0];
      wr_be     = 4'b0000;
      wr_data   = wdata_q;
      tag_we    = 1'b0;
      tag_valid = 1'b0;
      tag_wd    = addr_q[AW-1 -: TAG_W];
      unique case (state_q)
         IDLE: begin
            if (cpu_wr) begin
               cpu_stall = 1'b1;
               addr_d    = cpu_addr[DATA_WIDTH-1:2];
               wdata_d   = cpu_wdata;
               wstrb_d   = cpu_wstrb;
               hit_d     = hit;
               state_d   = WRITE;
            end else if (cpu_rd && !hit) begin
               // The victim line is invalidated up front so a partial refill is never visible.
               cpu_stall = 1'b1;
               addr_d    = cpu_addr[DATA_WIDTH-1:2];
               beat_d    = '0;
               tag_we    = 1'b1;
               wr_idx    = cpu_addr[OFF_W+2 +: IDX_W];
               tag_wd    = cpu_addr[DATA_WIDTH-1 -: TAG_W];
               state_d   = REFILL;
            end
         end
         REFILL: begin
            cpu_stall = 1'b1;
            mem_req   = 1'b1;
            mem_addr  = {addr_q[AW-1:OFF_W], beat_q, 2'b00};
            if (mem_ready) begin
               wr_off  = beat_q;
               wr_be   = 4'b1111;
               wr_data = mem_rdata;
               beat_d  = beat_q + OFF_W'(1);
               if (beat_q == OFF_W'(WORDS - 1)) begin
                  tag_we    = 1'b1;
                  tag_valid = 1'b1;
                  state_d   = DONE;
               end
            end
         end
         WRITE: begin
            cpu_stall = 1'b1;
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {addr_q, 2'b00};
            mem_wdata = wdata_q;
            mem_wstrb = wstrb_q;
            if (mem_ready) begin
               wr_be   = hit_q ? wstrb_q : 4'b0000;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: memory-level cache model, bus scoreboard and literal pins.
module tb_dcache_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_rd, cpu_wr;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic [3:0]  cpu_wstrb;
   logic        cpu_stall;
   logic        mem_req, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   always #5 clk = ~clk;

   dcache_ctrl #(.LINES(16), .WORDS(4), .DATA_WIDTH(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cpu_rd   (cpu_rd),
      .cpu_wr   (cpu_wr),
      .cpu_addr (cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_wstrb(cpu_wstrb),
      .cpu_rdata(cpu_rdata),
      .cpu_stall(cpu_stall),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready),
      .mem_rdata(mem_rdata)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Backing memory: untouched word at byte address a holds 0x1000_0000 + a/4.
   logic [31:0] mem_m [int];

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      int k;
      k = int'(a >> 2);
      if (mem_m.exists(k)) return mem_m[k];
      return 32'h1000_0000 + (a >> 2);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
      return r;
   endfunction

   // Cache model: which 16-byte line each of the 16 sets holds.
   int line_m  [16];
   bit valid_m [16];

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
   } beat_t;
   beat_t exp_q[$];

   int          ready_delay = 0;
   int          wait_cnt    = 0;
   int          beats_done  = 0;
   bit          prev_wait   = 0;
   logic        prev_we;
   logic [31:0] prev_addr, prev_wdata;
   logic [3:0]  prev_strb;

   // Memory responder and bus scoreboard.
   always @(negedge clk) begin
      beat_t e;
      if (rst_n !== 1'b1) begin
         prev_wait = 0;
         wait_cnt  = 0;
         mem_ready = 1'b0;
      end else begin
         if (prev_wait) begin
            check32("hold_req", {31'd0, mem_req}, 32'd1);
            check32("hold_addr", mem_addr, prev_addr);
            check32("hold_we", {31'd0, mem_we}, {31'd0, prev_we});
            check32("hold_wdata", mem_wdata, prev_wdata);
            check32("hold_strb", {28'd0, mem_wstrb}, {28'd0, prev_strb});
         end
         if (mem_req === 1'b1) begin
            if (wait_cnt < ready_delay) begin
               mem_ready = 1'b0;
               wait_cnt++;
            end else begin
               mem_ready = 1'b1;
               wait_cnt  = 0;
            end
            mem_rdata = mem_read(mem_addr);
            if (mem_ready) begin
               beats_done++;
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_beat actual_addr=%h required=none", mem_addr);
               end else begin
                  e = exp_q.pop_front();
                  check32("beat_we", {31'd0, mem_we}, {31'd0, e.we});
                  check32("beat_addr", mem_addr, e.addr);
                  if (e.we) begin
                     check32("beat_wdata", mem_wdata, e.wdata);
                     check32("beat_strb", {28'd0, mem_wstrb}, {28'd0, e.strb});
                  end
               end
            end
            prev_wait  = !mem_ready;
            prev_addr  = mem_addr;
            prev_we    = mem_we;
            prev_wdata = mem_wdata;
            prev_strb  = mem_wstrb;
         end else begin
            mem_ready = 1'b1;
            mem_rdata = 32'hDEAD_BEEF;
            prev_wait = 0;
            wait_cnt  = 0;
         end
      end
   end

   task automatic do_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb, input string name,
                        output int stalls, output logic [31:0] rdata);
      int          idx, line, exp_stall;
      bit          hit;
      logic [31:0] exp_rd;
      beat_t       b;
      idx  = int'((addr >> 4) & 32'hF);
      line = int'(addr >> 4);
      hit  = valid_m[idx] && (line_m[idx] == line);
      exp_rd = mem_read(addr);
      if (wr) begin
         exp_stall = 2 + ready_delay;
         b.we = 1'b1; b.addr = {addr[31:2], 2'b00}; b.wdata = wdata; b.strb = strb;
         exp_q.push_back(b);
      end else if (hit) begin
         exp_stall = 0;
      end else begin
         exp_stall = 1 + 4 * (1 + ready_delay);
         for (int i = 0; i < 4; i++) begin
            b.we = 1'b0; b.addr = {addr[31:4], 4'h0} + 32'(4 * i); b.wdata = '0; b.strb = '0;
            exp_q.push_back(b);
         end
      end
      @(negedge clk);
      cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = strb;
      #1;
      stalls = 0;
      while (cpu_stall !== 1'b0 && stalls < 300) begin
         stalls++;
         @(negedge clk);
         #1;
      end
      rdata = cpu_rdata;
      check32({name, "_stall"}, 32'(stalls), 32'(exp_stall));
      if (!wr) check32({name, "_rdata"}, rdata, exp_rd);
      @(negedge clk);
      cpu_rd = 1'b0; cpu_wr = 1'b0;
      if (wr) begin
         mem_m[int'(addr >> 2)] = merge(mem_read(addr), wdata, strb);
      end else if (!hit) begin
         valid_m[idx] = 1'b1;
         line_m[idx]  = line;
      end
   endtask

   initial begin
      int          s, start;
      logic [31:0] r;
      beat_t       b;
      rst_n = 1'b0;
      cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0; cpu_wstrb = 0;
      mem_ready = 0; mem_rdata = 0;
      for (int i = 0; i < 16; i++) begin valid_m[i] = 0; line_m[i] = -1; end
      repeat (3) @(negedge clk);
      check32("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check32("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check32("rst_mem_addr", mem_addr, 32'd0);
      check32("rst_mem_wdata", mem_wdata, 32'd0);
      check32("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
      check32("rst_stall", {31'd0, cpu_stall}, 32'd0);
      rst_n = 1'b1;

      do_op(1, 0, 32'h40, 0, 0, "cold_load", s, r);
      check32("cold_stall_lit", 32'(s), 32'd5);
      check32("cold_rdata_lit", r, 32'h1000_0010);
      do_op(1, 0, 32'h40, 0, 0, "warm_load", s, r);
      check32("warm_stall_lit", 32'(s), 32'd0);

      do_op(0, 1, 32'h44, 32'hAABB_CCDD, 4'b0011, "store_hit", s, r);
      check32("store_stall_lit", 32'(s), 32'd2);
      do_op(1, 0, 32'h44, 0, 0, "load_merged", s, r);
      check32("merged_rdata_lit", r, 32'h1000_CCDD);

      do_op(0, 1, 32'h1000, 32'h1234_5678, 4'b1111, "store_miss", s, r);
      do_op(1, 0, 32'h1000, 0, 0, "load_after_store_miss", s, r);
      check32("no_alloc_stall_lit", 32'(s), 32'd5);

      do_op(1, 0, 32'h440, 0, 0, "conflict_load", s, r);
      do_op(1, 0, 32'h40, 0, 0, "evicted_load", s, r);
      check32("evicted_stall_lit", 32'(s), 32'd5);

      ready_delay = 3;
      do_op(1, 0, 32'h80, 0, 0, "slow_refill", s, r);
      check32("slow_stall_lit", 32'(s), 32'd17);
      do_op(0, 1, 32'h84, 32'h0000_00EE, 4'b0001, "slow_store", s, r);
      ready_delay = 0;
      do_op(1, 0, 32'h84, 0, 0, "slow_store_readback", s, r);

      do_op(1, 1, 32'h48, 32'h5566_0000, 4'b1100, "rd_wr_both", s, r);
      do_op(1, 0, 32'h48, 0, 0, "rd_wr_readback", s, r);
      check32("rd_wr_rdata_lit", r, 32'h5566_0012);

      // Reset in the cycle the third refill beat is on the bus.
      start = beats_done;
      for (int i = 0; i < 4; i++) begin
         b.we = 1'b0; b.addr = 32'h100 + 32'(4 * i); b.wdata = '0; b.strb = '0;
         exp_q.push_back(b);
      end
      @(negedge clk);
      cpu_rd = 1'b1; cpu_addr = 32'h100;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         #2;
         if (beats_done >= start + 3) break;
      end
      check32("reset_beat_reached", 32'(beats_done - start), 32'd3);
      rst_n = 1'b0;
      cpu_rd = 1'b0;
      #1;
      check32("midrst_mem_req", {31'd0, mem_req}, 32'd0);
      check32("midrst_stall", {31'd0, cpu_stall}, 32'd0);
      exp_q.delete();
      for (int i = 0; i < 16; i++) valid_m[i] = 0;
      @(negedge clk);
      rst_n = 1'b1;
      do_op(1, 0, 32'h100, 0, 0, "post_reset_load", s, r);
      check32("post_reset_stall_lit", 32'(s), 32'd5);
      do_op(1, 0, 32'h40, 0, 0, "post_reset_other", s, r);
      check32("post_reset_other_lit", 32'(s), 32'd5);

      repeat (3) @(negedge clk);
      check32("pending_beats", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
